// File: rtl/euler_writeback_if.sv
// Row-result handshake and state-memory port bundle for the Euler write-back stage.
// master: the write-back stage; slave: the pipeline/memory environment.
interface euler_writeback_if #(
    parameter int unsigned ADD_SIZE  = 16,
    parameter int unsigned DATA_SIZE = 16
);
    logic                 acc_valid;
    logic [DATA_SIZE-1:0] acc_data;
    logic                 acc_overflow;
    logic                 row_ack;

    logic                 mem_rd_en;
    logic [ADD_SIZE-1:0]  mem_rd_addr;
    logic [DATA_SIZE-1:0] mem_rd_data;
    logic                 mem_wr_en;
    logic [ADD_SIZE-1:0]  mem_wr_addr;
    logic [DATA_SIZE-1:0] mem_wr_data;

    modport master (
        input  acc_valid, acc_data, acc_overflow, mem_rd_data,
        output row_ack, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output acc_valid, acc_data, acc_overflow, mem_rd_data,
        input  row_ack, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/euler_writeback.sv
// Euler update stage: x[i] <= sat(x[i] + sat((h*acc[i]) >>> FRAC_BITS)) for each finished row,
// with read-modify-write of the state memory and a per-row acknowledge.
module euler_writeback #(
    parameter int unsigned ADD_SIZE  = 16,
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned MAX_DIM   = 6,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_SIZE-1:0]  x_base,
    input  logic [MAX_DIM-1:0]   n_rows,
    input  logic [DATA_SIZE-1:0] h_step,
    euler_writeback_if.master    bus,
    output logic                 busy,
    output logic                 final_done,
    output logic                 overflow
);
    localparam int unsigned PROD_W = 2 * DATA_SIZE;
    localparam int unsigned SUM_W  = DATA_SIZE + 1;
    localparam logic [DATA_SIZE-1:0] D_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] D_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;

    state_t                       state;
    logic [ADD_SIZE-1:0]          base_r;
    logic [MAX_DIM-1:0]           rows_r;
    logic [MAX_DIM-1:0]           row_idx;
    logic signed [DATA_SIZE-1:0]  h_r;
    logic signed [DATA_SIZE-1:0]  acc_r;
    logic                         armed;

    logic [ADD_SIZE-1:0]          row_addr;
    logic                         last_row;

    logic signed [PROD_W-1:0]     prod;
    logic signed [PROD_W-1:0]     prod_shr;
    logic [PROD_W-DATA_SIZE:0]    prod_hi;
    logic                         mul_sat;
    logic signed [DATA_SIZE-1:0]  scaled;
    logic signed [SUM_W-1:0]      sum_ext;
    logic                         add_sat;
    logic [DATA_SIZE-1:0]         sum_sat;

    assign row_addr = base_r + ADD_SIZE'(row_idx);
    assign last_row = (row_idx == rows_r - MAX_DIM'(1));

    // Scale h*acc back to the data format (floor shift), then add to the old state; both steps saturate.
    always_comb begin
        prod     = PROD_W'(h_r) * PROD_W'(acc_r);
        prod_shr = prod >>> FRAC_BITS;
        prod_hi  = prod_shr[PROD_W-1:DATA_SIZE-1];
        mul_sat  = !((prod_hi == '0) || (prod_hi == '1));
        if (mul_sat) begin
            scaled = prod_shr[PROD_W-1] ? D_MIN : D_MAX;
        end else begin
            scaled = prod_shr[DATA_SIZE-1:0];
        end
        sum_ext = SUM_W'($signed(bus.mem_rd_data)) + SUM_W'(scaled);
        add_sat = sum_ext[SUM_W-1] ^ sum_ext[SUM_W-2];
        if (add_sat) begin
            sum_sat = sum_ext[SUM_W-1] ? D_MIN : D_MAX;
        end else begin
            sum_sat = sum_ext[DATA_SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            base_r          <= '0;
            rows_r          <= '0;
            row_idx         <= '0;
            h_r             <= '0;
            acc_r           <= '0;
            armed           <= 1'b1;
            busy            <= 1'b0;
            final_done      <= 1'b0;
            overflow        <= 1'b0;
            bus.row_ack     <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
        end else begin
            bus.mem_rd_en <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.row_ack   <= 1'b0;
            final_done    <= 1'b0;

            // A low acc_valid re-arms capture, so a level held across row_ack is taken only once.
            if (!bus.acc_valid) begin
                armed <= 1'b1;
            end
            if (busy && bus.acc_overflow) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= x_base;
                        rows_r   <= n_rows;
                        h_r      <= h_step;
                        overflow <= 1'b0;
                        row_idx  <= '0;
                        armed    <= 1'b1;
                        busy     <= 1'b1;
                        if (n_rows == '0) begin
                            final_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.acc_valid && armed) begin
                        acc_r           <= bus.acc_data;
                        armed           <= 1'b0;
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= row_addr;
                        state           <= READ;
                    end
                end
                READ: begin
                    bus.mem_wr_data <= sum_sat;
                    if (mul_sat || add_sat) begin
                        overflow <= 1'b1;
                    end
                    bus.mem_wr_en   <= 1'b1;
                    bus.mem_wr_addr <= row_addr;
                    bus.row_ack     <= 1'b1;
                    state           <= WRITE;
                end
                WRITE: begin
                    if (last_row) begin
                        final_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        row_idx <= row_idx + MAX_DIM'(1);
                        state   <= WAIT;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_euler_writeback.sv
// Directed bench for euler_writeback: single-row vector table plus multi-row, held-valid,
// empty-job, ignored-start, upstream-overflow and mid-operation reset sequences.
module tb_euler_writeback;
    localparam int unsigned ADD_SIZE  = 16;
    localparam int unsigned DATA_SIZE = 16;
    localparam int unsigned MAX_DIM   = 6;
    localparam int unsigned FRAC_BITS = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADD_SIZE-1:0]  x_base;
    logic [MAX_DIM-1:0]   n_rows;
    logic [DATA_SIZE-1:0] h_step;
    logic                 busy;
    logic                 final_done;
    logic                 overflow;

    euler_writeback_if #(.ADD_SIZE(ADD_SIZE), .DATA_SIZE(DATA_SIZE)) bus ();

    euler_writeback #(
        .ADD_SIZE(ADD_SIZE), .DATA_SIZE(DATA_SIZE), .MAX_DIM(MAX_DIM), .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x_base(x_base), .n_rows(n_rows),
        .h_step(h_step), .bus(bus.master), .busy(busy), .final_done(final_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // State memory: data presented while the read strobe is up, sampled by the DUT at the edge ending it.
    logic [15:0] mem [256];
    assign bus.mem_rd_data = bus.mem_rd_en ? mem[bus.mem_rd_addr[7:0]] : 16'hDEAD;
    always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_wr_addr[7:0]] <= bus.mem_wr_data;

    int n_vec  = 0;
    int n_fail = 0;
    int n_rd   = 0;
    int n_wr   = 0;
    int n_ack  = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe bookkeeping and overlap check, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_rd_en) n_rd++;
        if (bus.mem_wr_en) n_wr++;
        if (bus.row_ack) n_ack++;
        if (final_done) n_done++;
        if (busy) begin
            chk("strobe_overlap",
                32'((bus.mem_rd_en && bus.mem_wr_en) ||
                    (final_done && (bus.mem_rd_en || bus.mem_wr_en || bus.row_ack)) ||
                    (bus.row_ack != bus.mem_wr_en)), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] x;
        logic [15:0] acc;
        logic [15:0] h;
        logic [15:0] exp_wr;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic wait_ack(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.row_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 1);
    endtask

    task automatic run_single(input string tag, input vec_t v, input logic [15:0] base);
        mem[base[7:0]] = v.x;
        x_base = base; n_rows = 6'd1; h_step = v.h;
        bus.acc_data = v.acc; bus.acc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 1);
        tick();
        chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 1);
        chk({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'(base));
        tick();
        chk({tag, "_wr_en"}, 32'(bus.mem_wr_en), 1);
        chk({tag, "_row_ack"}, 32'(bus.row_ack), 1);
        chk({tag, "_wr_addr"}, 32'(bus.mem_wr_addr), 32'(base));
        chk({tag, "_wr_data"}, 32'(bus.mem_wr_data), 32'(v.exp_wr));
        bus.acc_valid = 1'b0;
        tick();
        chk({tag, "_final_done"}, 32'(final_done), 1);
        chk({tag, "_wr_en_off"}, 32'(bus.mem_wr_en), 0);
        chk({tag, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_done_pulse"}, 32'(final_done), 0);
        chk({tag, "_overflow_held"}, 32'(overflow), 32'(v.exp_ovf));
    endtask

    // Rows of acc=(r+1)*1.0 with h=1.0 onto zeroed state: each write equals its acc.
    task automatic run_rows(input string tag, input logic [15:0] base, input int n);
        int a0;
        int d0;
        logic [15:0] addr;
        for (int r = 0; r < n; r++) begin
            addr = base + 16'(r);
            mem[addr[7:0]] = 16'h0000;
        end
        a0 = n_ack; d0 = n_done;
        x_base = base; n_rows = 6'(n); h_step = 16'h0100;
        bus.acc_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < n; r++) begin
            bus.acc_data = 16'((r + 1) * 256);
            bus.acc_valid = 1'b1;
            wait_ack($sformatf("%s_ack%0d", tag, r));
            chk($sformatf("%s_wr_addr%0d", tag, r), 32'(bus.mem_wr_addr), 32'(16'(base + 16'(r))));
            chk($sformatf("%s_wr_data%0d", tag, r), 32'(bus.mem_wr_data), 32'((r + 1) * 256));
            chk($sformatf("%s_early_done%0d", tag, r), 32'(final_done), 0);
            bus.acc_valid = 1'b0;
            tick();
        end
        chk({tag, "_final_done"}, 32'(final_done), 1);
        tick();
        chk({tag, "_ack_count"}, 32'(n_ack - a0), 32'(n));
        chk({tag, "_done_count"}, 32'(n_done - d0), 1);
        chk({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        int r0;
        int w0;
        int a0;
        int d0;

        vecs[0] = '{x: 16'h0100, acc: 16'h0200, h: 16'h0080, exp_wr: 16'h0200, exp_ovf: 1'b0};
        vecs[1] = '{x: 16'h7F00, acc: 16'h7F00, h: 16'h0100, exp_wr: 16'h7FFF, exp_ovf: 1'b1};
        vecs[2] = '{x: 16'h0100, acc: 16'hFE00, h: 16'h0080, exp_wr: 16'h0000, exp_ovf: 1'b0};
        vecs[3] = '{x: 16'h8100, acc: 16'h8000, h: 16'h0100, exp_wr: 16'h8000, exp_ovf: 1'b1};
        vecs[4] = '{x: 16'h0000, acc: 16'h7FFF, h: 16'h7FFF, exp_wr: 16'h7FFF, exp_ovf: 1'b1};
        vecs[5] = '{x: 16'h0005, acc: 16'hFFFF, h: 16'h0001, exp_wr: 16'h0004, exp_ovf: 1'b0};
        vecs[6] = '{x: 16'h0200, acc: 16'h0300, h: 16'hFF00, exp_wr: 16'hFF00, exp_ovf: 1'b0};
        vecs[7] = '{x: 16'h7FFF, acc: 16'h8000, h: 16'h7FFF, exp_wr: 16'hFFFF, exp_ovf: 1'b1};

        rst = 1'b1; start = 1'b0; x_base = '0; n_rows = '0; h_step = '0;
        bus.acc_valid = 1'b0; bus.acc_data = '0; bus.acc_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
        chk("rst_rd_addr", 32'(bus.mem_rd_addr), 0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_wr_addr", 32'(bus.mem_wr_addr), 0);
        chk("rst_wr_data", 32'(bus.mem_wr_data), 0);
        chk("rst_row_ack", 32'(bus.row_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_final_done", 32'(final_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_single($sformatf("v%0d", i), vecs[i], 16'(16'h0020 + 16'(i)));
        end

        run_rows("multi", 16'h0010, 3);
        chk("multi_mem2", 32'(mem[8'h12]), 32'h0300);
        run_rows("wrap", 16'hFFFF, 2);

        // Held valid across row_ack, plus a start pulse while busy that must be ignored.
        mem[8'h30] = 16'h0000; mem[8'h31] = 16'h0005;
        r0 = n_rd; a0 = n_ack; d0 = n_done;
        x_base = 16'h0030; n_rows = 6'd2; h_step = 16'h0100;
        bus.acc_data = 16'h0011; bus.acc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("held_rd_count", 32'(n_rd - r0), 1);
        chk("held_ack_count", 32'(n_ack - a0), 1);
        chk("held_busy", 32'(busy), 1);
        x_base = 16'h0050; n_rows = 6'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("held_no_recapture", 32'(bus.mem_rd_en), 0);
        bus.acc_valid = 1'b0; bus.acc_data = 16'h0022;
        tick();
        bus.acc_valid = 1'b1;
        wait_ack("held_ack2");
        chk("held_wr_addr2", 32'(bus.mem_wr_addr), 32'h0031);
        chk("held_wr_data2", 32'(bus.mem_wr_data), 32'h0027);
        bus.acc_valid = 1'b0;
        tick();
        chk("held_final_done", 32'(final_done), 1);
        tick();
        chk("held_rd_total", 32'(n_rd - r0), 2);
        chk("held_done_count", 32'(n_done - d0), 1);
        chk("held_idle", 32'(busy), 0);

        // Empty job: immediate completion, no memory traffic.
        r0 = n_rd; w0 = n_wr;
        x_base = 16'h0060; n_rows = 6'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_final_done", 32'(final_done), 1);
        chk("empty_busy", 32'(busy), 1);
        tick();
        chk("empty_done_pulse", 32'(final_done), 0);
        chk("empty_idle", 32'(busy), 0);
        chk("empty_rd_count", 32'(n_rd - r0), 0);
        chk("empty_wr_count", 32'(n_wr - w0), 0);

        // Upstream overflow while busy, then reset in READ aborts the pending write.
        x_base = 16'h0040; n_rows = 6'd1; h_step = 16'h0080; start = 1'b1;
        tick();
        start = 1'b0;
        bus.acc_overflow = 1'b1;
        tick();
        bus.acc_overflow = 1'b0;
        chk("accovf_overflow", 32'(overflow), 1);
        tick();
        bus.acc_data = 16'h0200; bus.acc_valid = 1'b1;
        tick();
        chk("rstmid_in_read", 32'(bus.mem_rd_en), 1);
        w0 = n_wr;
        rst = 1'b1;
        tick();
        chk("rstmid_rd_en", 32'(bus.mem_rd_en), 0);
        chk("rstmid_rd_addr", 32'(bus.mem_rd_addr), 0);
        chk("rstmid_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rstmid_wr_addr", 32'(bus.mem_wr_addr), 0);
        chk("rstmid_wr_data", 32'(bus.mem_wr_data), 0);
        chk("rstmid_row_ack", 32'(bus.row_ack), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_final_done", 32'(final_done), 0);
        chk("rstmid_overflow", 32'(overflow), 0);
        rst = 1'b0; bus.acc_valid = 1'b0;
        repeat (2) tick();
        chk("rstmid_no_write", 32'(n_wr - w0), 0);
        run_single("after_rst", vecs[0], 16'h0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
